midi_uart_rx: RTL
=================

MIDI_UART_RX -- requirements
Module: midi_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 32, clk cycles per serial bit (32 = 31250 baud at 1 MHz); SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ser_i  input  1  MIDI serial line, asynchronous to clk, idle high.
REQ-005 data_o  output  8  received byte, LSB-first assembled.
REQ-006 valid_o  output  1  data_o holds an unconsumed byte.
REQ-007 ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
REQ-008 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun_o  output  1  one-cycle pulse: completed byte dropped, holding register full.
REQ-010 busy_o  output  1  high in any state other than IDLE.

Function
REQ-011 ser_i SHALL pass through a 2-flop synchronizer (flops reset to 1); all logic uses the synchronized value ser_s.
REQ-012 FSM states: IDLE, START, DATA, STOP, BREAK; one bit counter (0..CLKS_PER_BIT-1), one bit index (0..7), 8-bit shift register.
REQ-013 IDLE: on ser_s == 0, go to START with bit counter cleared.
REQ-014 START: at counter == CLKS_PER_BIT/2-1 sample ser_s; 0 -> DATA, counter cleared, index 0; 1 -> glitch, back to IDLE, no outputs touched.
REQ-015 DATA: sample ser_s at each counter == CLKS_PER_BIT-1 (mid-bit), shift in at bit [7] shifting right (LSB first); after index 7 go to STOP.
REQ-016 STOP: at counter == CLKS_PER_BIT-1 sample ser_s; 1 -> byte complete, go IDLE; 0 -> frame_err_o = 1 next cycle, byte discarded, go BREAK.
REQ-017 BREAK: stay until ser_s == 1, then IDLE; a held-low line (MIDI break) SHALL produce exactly one frame_err_o pulse.
REQ-018 Byte complete: shift register copied to data_o and valid_o set on the clk edge following the stop-bit sample (1-cycle latency).
REQ-019 valid_o SHALL stay high and data_o stable until a cycle with valid_o && ready_i; valid_o clears on the following edge.
REQ-020 Completion while valid_o = 1 and ready_i = 0: data_o unchanged, valid_o stays 1, overrun_o = 1 for one cycle, new byte lost.
REQ-021 Completion in the same cycle as valid_o && ready_i: new byte loaded, valid_o stays 1, no overrun_o.
REQ-022 ready_i with valid_o = 0 SHALL have no effect.
REQ-023 Receive SHALL continue independent of consumer stall; back-to-back frames with zero idle between stop and next start SHALL be received.
REQ-024 frame_err_o and overrun_o SHALL never be high in consecutive cycles for one event, and never both high from the same frame.

Reset
REQ-025 rst_n low: state IDLE, counters 0, shift reg 0x00, data_o = 0x00, valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0, synchronizer = 1.
REQ-026 Reset mid-frame SHALL abandon the frame; after release a line still low SHALL be treated as a new start edge only via START qualification (may yield frame_err_o); no partial byte reaches data_o.

Verification
REQ-027 Send 0x90 (CLKS_PER_BIT = 32), ready_i = 1 -> data_o = 0x90, valid_o one cycle, frame_err_o = 0, overrun_o = 0.
REQ-028 Send 0x3C then 0x7F back-to-back, ready_i = 0 -> data_o = 0x3C held, valid_o = 1, overrun_o pulses once at second stop; then ready_i = 1 -> valid_o clears next edge.
REQ-029 ser_i low for 10 clks then high -> returns to IDLE, no valid_o, no frame_err_o, busy_o low again.
REQ-030 Frame 0x55 with stop bit driven 0, line held low 400 clks -> exactly one frame_err_o pulse, no valid_o; next good frame 0xF8 received correctly.
REQ-031 rst_n asserted at data bit 4 of 0xAA -> all outputs at reset values immediately; next frame 0x12 after line idle received as 0x12.
REQ-032 Byte completes in cycle where valid_o && ready_i (old 0x01, new 0x02) -> data_o = 0x02, valid_o stays 1, overrun_o = 0.

Source files
------------

// File: rtl/midi_uart_rx.sv
// midi_uart_rx
//   MIDI serial receiver. It handles 8 data bits, no parity and one stop bit, sent LSB first.
//   The line is sampled in the middle of each bit. After the start edge the receiver waits
//   half a bit, checks that the line is still low, and then samples each following bit one
//   full bit period apart.
//   A received byte is held in a one-entry output register with a valid/ready handshake.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   ser_i        MIDI serial line, asynchronous to clk, idle high
//   data_o       received byte
//   valid_o      data_o holds a byte that has not been consumed
//   ready_i      consumer accepts data_o when valid_o && ready_i
//   frame_err_o  one-cycle pulse: stop bit sampled low (MIDI break gives exactly one pulse)
//   overrun_o    one-cycle pulse: a completed byte was dropped because data_o was still full
//   busy_o       receiver is in any state other than idle
//
// Parameter
//   CLKS_PER_BIT clk cycles per serial bit; must be even and >= 4

module midi_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Two-flop synchronizer. It resets to the idle-high line level.
    logic ser_m;
    logic ser_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_m <= 1'b1;
            ser_s <= 1'b1;
        end else begin
            ser_m <= ser_i;
            ser_s <= ser_m;
        end
    end

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       idx;
    logic [2:0]       idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic [7:0]       data_n;
    logic             valid_n;
    logic             ferr_n;
    logic             ovr_n;
    logic             byte_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            data_o      <= data_n;
            valid_o     <= valid_n;
            frame_err_o <= ferr_n;
            overrun_o   <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        byte_done = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (!ser_s) begin
                    state_n = S_START;
                    cnt_n   = '0;
                end
            end

            // Check the start bit again half a bit after the edge. This rejects glitches.
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    if (!ser_s) begin
                        state_n = S_DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // The count is aligned to mid-bit, so each full bit period lands on the next mid-bit.
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {ser_s, shreg[7:1]};
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (ser_s) begin
                        byte_done = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // Wait here while the line is held low. The only frame error pulse is raised
            // on entry, so a MIDI break produces one pulse.
            S_BREAK: begin
                if (ser_s) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output holding register. A byte completes while the old byte is being accepted in the
    // same cycle: the new byte replaces it and valid stays high.
    always_comb begin
        data_n  = data_o;
        valid_n = valid_o;
        ovr_n   = 1'b0;

        if (valid_o && ready_i) begin
            valid_n = 1'b0;
        end

        if (byte_done) begin
            if (valid_o && !ready_i) begin
                ovr_n = 1'b1;
            end else begin
                data_n  = shreg;
                valid_n = 1'b1;
            end
        end
    end

    assign busy_o = (state != S_IDLE);

    a_err_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(frame_err_o && overrun_o));

    a_ferr_single : assert property (@(posedge clk) disable iff (!rst_n)
        frame_err_o |=> !frame_err_o);

endmodule
